// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : Sequencer for a direct-mapped 256-line x 16-word cache.
//                Handles single-word CPU reads/writes, tag lookup, full-line
//                refill on read miss, and write-through on every store.
//                Write hits are followed by a line re-fill because the cache
//                array has no partial-write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_controller #(
   parameter int WORD_W  = 32,
   parameter int WORDS   = 16,
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   // CPU port
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [31:0]               cpu_addr,
   input  logic [WORD_W-1:0]         cpu_wdata,
   output logic [WORD_W-1:0]         cpu_rdata,
   output logic                      cpu_ready,
   output logic                      cpu_busy,
   // cache array port
   output logic                      cache_mode,
   output logic [INDEX_W-1:0]        cache_index,
   output logic [$clog2(WORDS)-1:0]  cache_blk_offset,
   output logic [TAG_W-1:0]          cache_tagin,
   output logic [WORDS*WORD_W-1:0]   cache_datain,
   input  logic [WORD_W-1:0]         cache_dataout,
   input  logic [TAG_W-1:0]          cache_tagout,
   input  logic                      cache_valid,
   // main memory port
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [31:0]               mem_addr,
   output logic [WORD_W-1:0]         mem_wdata,
   input  logic [WORD_W-1:0]         mem_rdata,
   input  logic                      mem_ack
);

   localparam int OFFSET_W = $clog2(WORDS);
   localparam int ADDR_W   = 32;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOOKUP    = 3'd1;
   localparam logic [2:0] S_COMPARE   = 3'd2;
   localparam logic [2:0] S_MEM_WRITE = 3'd3;
   localparam logic [2:0] S_REFILL    = 3'd4;
   localparam logic [2:0] S_FILL      = 3'd5;
   localparam logic [2:0] S_RESPOND   = 3'd6;

   localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS - 1);

   logic [2:0]              state;
   logic [OFFSET_W-1:0]     beat;
   logic [ADDR_W-1:0]       req_addr;
   logic                    req_we;
   logic [WORD_W-1:0]       req_wdata;
   logic                    wr_hit;
   logic [WORDS*WORD_W-1:0] line_buf;
   logic [WORD_W-1:0]       rdata_q;

   logic [TAG_W-1:0]        req_tag;
   logic [INDEX_W-1:0]      req_index;
   logic [OFFSET_W-1:0]     req_offset;
   logic                    hit;

   // Address fields of the latched request.
   assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
   assign req_index  = req_addr[OFFSET_W +: INDEX_W];
   assign req_offset = req_addr[OFFSET_W-1:0];

   // Cache outputs are registered by the array, so they reflect the LOOKUP
   // issued in the previous cycle while we sit in COMPARE.
   assign hit = cache_valid & (cache_tagout == req_tag);

   // Control FSM plus request latch, refill beat counter and line buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         beat      <= '0;
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
         wr_hit    <= 1'b0;
         line_buf  <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_req) begin
                  req_addr  <= cpu_addr;
                  req_we    <= cpu_we;
                  req_wdata <= cpu_wdata;
                  state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               state <= S_COMPARE;
            end
            S_COMPARE: begin
               if (req_we) begin
                  // Remember residency so the store can re-fill the line.
                  wr_hit <= hit;
                  state  <= S_MEM_WRITE;
               end else if (hit) begin
                  rdata_q <= cache_dataout;
                  state   <= S_RESPOND;
               end else begin
                  beat  <= '0;
                  state <= S_REFILL;
               end
            end
            S_MEM_WRITE: begin
               if (mem_ack) begin
                  if (wr_hit) begin
                     beat  <= '0;
                     state <= S_REFILL;
                  end else begin
                     // No write-allocate: a store miss leaves the cache alone.
                     state <= S_RESPOND;
                  end
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  line_buf[int'(beat)*WORD_W +: WORD_W] <= mem_rdata;
                  beat <= beat + 1'b1;
                  if (beat == LAST_BEAT) begin
                     state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               // Reads take their word straight from the buffer; no re-read.
               if (!req_we) begin
                  rdata_q <= line_buf[int'(req_offset)*WORD_W +: WORD_W];
               end
               state <= S_RESPOND;
            end
            S_RESPOND: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Memory bus drive: address/data are zero whenever no request is open.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == S_MEM_WRITE) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = req_addr;
         mem_wdata = req_wdata;
      end else if (state == S_REFILL) begin
         mem_req  = 1'b1;
         mem_addr = {req_addr[ADDR_W-1:OFFSET_W], beat};
      end
   end

   assign cpu_rdata        = rdata_q;
   assign cpu_ready        = (state == S_RESPOND);
   assign cpu_busy         = (state != S_IDLE);
   assign cache_mode       = (state == S_FILL);
   assign cache_index      = req_index;
   assign cache_blk_offset = req_offset;
   assign cache_tagin      = req_tag;
   assign cache_datain     = line_buf;

endmodule
`default_nettype wire
